// File: rtl/i2c_target_adxl357_emu.sv
// i2c_target_adxl357_emu: I2C target that mimics the ADXL355/357 register file.
// Ports: i_clk/i_rst sync reset; i_scl/i_sda pads, o_sda_oe pulls SDA low;
// i_accx/y/z, i_temp sample inputs; o_range/o_power_ctl writable regs;
// o_busy while addressed; o_drdy pulse only when ADXL_EMU_DRDY_EN is defined.
module i2c_target_adxl357_emu #(
  parameter logic [6:0] DEV_ADDR = 7'h1D,
  parameter int         DRDY_DIV = 12500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  input  logic [19:0] i_accx,
  input  logic [19:0] i_accy,
  input  logic [19:0] i_accz,
  input  logic [11:0] i_temp,
  output logic [7:0]  o_range,
  output logic [7:0]  o_power_ctl,
  output logic        o_busy,
  output logic        o_drdy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_q, scl_d, sda_q, sda_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d, ptr_q, ptr_d;
  logic        rw_q, rw_d, oe_q, oe_d, busy_q, busy_d;
  logic [7:0]  range_q, range_d, pctl_q, pctl_d;
  logic [19:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [11:0] t_q, t_d;
  logic        sda_s, scl_rise, scl_fall, start, stop, byte_end;
  logic [7:0]  sh_in, rd_byte;

  // [0],[1] synchronise, [2] is history for edge detection
  assign scl_d    = {scl_q[1:0], i_scl};
  assign sda_d    = {sda_q[1:0], i_sda};
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sh_in    = {sh_q[6:0], sda_s};
  assign byte_end = scl_fall & (cnt_q == 4'd8);

  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      8'h00: rd_byte = 8'hAD;
      8'h01: rd_byte = 8'h1D;
      8'h02: rd_byte = 8'hED;
      8'h03: rd_byte = 8'h01;
      8'h06: rd_byte = {4'h0, t_q[11:8]};
      8'h07: rd_byte = t_q[7:0];
      8'h08: rd_byte = x_q[19:12];
      8'h09: rd_byte = x_q[11:4];
      8'h0A: rd_byte = {x_q[3:0], 4'h0};
      8'h0B: rd_byte = y_q[19:12];
      8'h0C: rd_byte = y_q[11:4];
      8'h0D: rd_byte = {y_q[3:0], 4'h0};
      8'h0E: rd_byte = z_q[19:12];
      8'h0F: rd_byte = z_q[11:4];
      8'h10: rd_byte = {z_q[3:0], 4'h0};
      8'h2C: rd_byte = range_q;
      8'h2D: rd_byte = pctl_q;
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    range_d = range_q;
    pctl_d  = pctl_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    t_d     = t_q;
    if (start) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + 4'd1;
          end else if (byte_end) begin
            oe_d    = 1'b1;
            state_d = state_e'(state_q + 4'd1);
            if (state_q == S_PTR) begin
              ptr_d = sh_q;
            end else if (state_q == S_WDATA) begin
              if (ptr_q == 8'h2C) range_d = sh_q;
              if (ptr_q == 8'h2D) pctl_d  = sh_q;
            end else if (sh_q[7:1] != DEV_ADDR) begin
              // Not ours: stay off the bus until the next START
              oe_d    = 1'b0;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              busy_d = 1'b1;
              rw_d   = sh_q[0];
              if (sh_q[0]) begin
                x_d = i_accx;
                y_d = i_accy;
                z_d = i_accz;
                t_d = i_temp;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              oe_d    = ~rd_byte[7];
              state_d = S_RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = S_PTR;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = S_WDATA;
            if (state_q == S_WDATA_ACK) ptr_d = ptr_q + 8'd1;
          end
        end
        S_RDATA: begin
          // ptr and snapshot are stable within a byte, so index rd_byte live
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (byte_end) begin
            oe_d    = 1'b0;
            state_d = S_RDATA_ACK;
          end else if (scl_fall) begin
            oe_d = ~rd_byte[3'd7 - cnt_q[2:0]];
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d   = ptr_q + 8'd1;
              cnt_d   = 4'd0;
              state_d = S_RDATA;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      ptr_q   <= 8'h00;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      range_q <= 8'h81;
      pctl_q  <= 8'h01;
      x_q     <= 20'h0;
      y_q     <= 20'h0;
      z_q     <= 20'h0;
      t_q     <= 12'h0;
    end else begin
      state_q <= state_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      range_q <= range_d;
      pctl_q  <= pctl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      t_q     <= t_d;
    end
  end

  assign o_sda_oe    = oe_q;
  assign o_busy      = busy_q;
  assign o_range     = range_q;
  assign o_power_ctl = pctl_q;

`ifdef ADXL_EMU_DRDY_EN
  localparam int CW = (DRDY_DIV > 2) ? $clog2(DRDY_DIV) : 1;
  logic [CW-1:0] div_q, div_d;
  logic          drdy_q, drdy_d;

  // Counter keeps running in standby; only the pulse is masked
  always_comb begin
    div_d  = div_q + CW'(1);
    drdy_d = 1'b0;
    if (div_q == CW'(DRDY_DIV - 1)) begin
      div_d  = '0;
      drdy_d = ~pctl_q[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q  <= '0;
      drdy_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      drdy_q <= drdy_d;
    end
  end

  assign o_drdy = drdy_q;
`else
  // DRDY_DIV has no effect without the divider; output is constant 0
  assign o_drdy = 1'b0 & (DRDY_DIV != 0);
`endif
endmodule
